// File: rtl/cpu_control_fsm.sv
// Multicycle control sequencer: fetch handshake, ARM data-processing decode,
// register-file read/execute/writeback sequencing and the architectural NZCV register.
module cpu_control_fsm #(
   parameter int RESET_IDLE_CYCLES = 2,
   parameter bit HALT_ON_UNDEF     = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] IR,
   input  logic        W_IR_valid,
   output logic        write_ir,
   output logic        write_pc,
   output logic [3:0]  NZCV,
   output logic [3:0]  rf_ra_addr,
   output logic [3:0]  rf_rb_addr,
   output logic [3:0]  rf_rs_addr,
   output logic [3:0]  rf_wr_addr,
   output logic        rf_write,
   output logic [3:0]  alu_op,
   output logic        alu_src_imm,
   input  logic [3:0]  alu_nzcv,
   input  logic        shifter_carry,
   output logic [2:0]  state,
   output logic        instr_retired,
   output logic        undef_instr
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [3:0] IDLE_LAST = 4'(RESET_IDLE_CYCLES - 1);

   state_t     cur_state, nxt_state;
   logic [3:0] idle_cnt;
   logic       cond_pass;
   logic       s_bit;
   logic       is_dp;
   logic       is_cmp;
   logic       is_arith;
   logic       unused_ir;

   assign unused_ir = ^{IR[31:28], IR[7:4]};
   assign state     = cur_state;
   assign is_dp     = (IR[27:26] == 2'b00);
   assign is_cmp    = (alu_op[3:2] == 2'b10);
   assign is_arith  = ((alu_op >= 4'h2) && (alu_op <= 4'h7)) ||
                      (alu_op == 4'hA) || (alu_op == 4'hB);

   always_comb begin
      nxt_state     = cur_state;
      write_ir      = 1'b0;
      write_pc      = 1'b0;
      rf_write      = 1'b0;
      instr_retired = 1'b0;
      undef_instr   = 1'b0;
      case (cur_state)
         IDLE: begin
            if (idle_cnt == IDLE_LAST) nxt_state = FETCH;
         end
         FETCH: begin
            write_ir  = 1'b1;
            write_pc  = 1'b1;
            nxt_state = DECODE;
         end
         DECODE: begin
            // A failed condition retires the instruction even if it would be undefined.
            if (!cond_pass) begin
               instr_retired = 1'b1;
               nxt_state     = FETCH;
            end else if (!is_dp) begin
               undef_instr = 1'b1;
               if (HALT_ON_UNDEF) begin
                  nxt_state = HALT;
               end else begin
                  instr_retired = 1'b1;
                  nxt_state     = FETCH;
               end
            end else begin
               nxt_state = EXEC;
            end
         end
         EXEC: begin
            if (is_cmp) begin
               instr_retired = 1'b1;
               nxt_state     = FETCH;
            end else begin
               nxt_state = WB;
            end
         end
         WB: begin
            rf_write      = 1'b1;
            instr_retired = 1'b1;
            nxt_state     = FETCH;
         end
         HALT:    nxt_state = HALT;
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state   <= IDLE;
         idle_cnt    <= 4'd0;
         cond_pass   <= 1'b0;
         s_bit       <= 1'b0;
         NZCV        <= 4'b0000;
         rf_ra_addr  <= 4'd0;
         rf_rb_addr  <= 4'd0;
         rf_rs_addr  <= 4'd0;
         rf_wr_addr  <= 4'd0;
         alu_op      <= 4'd0;
         alu_src_imm <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         if ((cur_state == IDLE) && (nxt_state == IDLE)) idle_cnt <= idle_cnt + 4'd1;
         else                                            idle_cnt <= 4'd0;
         if (cur_state == FETCH) cond_pass <= W_IR_valid;
         // Operand fields are captured once so they stay stable through EXEC and WB.
         if ((cur_state == DECODE) && (nxt_state == EXEC)) begin
            rf_ra_addr  <= IR[19:16];
            rf_rb_addr  <= IR[3:0];
            rf_rs_addr  <= IR[11:8];
            rf_wr_addr  <= IR[15:12];
            alu_op      <= IR[24:21];
            alu_src_imm <= IR[25];
            s_bit       <= IR[20];
         end
         if ((cur_state == EXEC) && s_bit) begin
            if (is_arith) NZCV <= alu_nzcv;
            else          NZCV <= {alu_nzcv[3:2], shifter_carry, NZCV[0]};
         end
      end
   end

endmodule
